// File: rtl/exec_unit_if.sv
// Instruction handshake between the fetch/decode stage and exec_unit.
interface exec_unit_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        done;
  logic        illegal;

  modport master (output in_valid, in_instr, input in_ready, done, illegal);
  modport slave  (input in_valid, in_instr, output in_ready, done, illegal);
endinterface

// File: rtl/exec_unit.sv
// Clocked register-file/ALU datapath: single-cycle mov/add/sub/logic,
// iterative shift-add multiply producing {SGPR, rdst}.
module exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  exec_unit_if.slave        bus,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CW = $clog2(DATA_W);

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0, OP_MOV = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3,
    OP_MUL     = 5'd4, OP_AND = 5'd5, OP_OR  = 5'd6, OP_XOR = 5'd7
  } op_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0]   gpr [NREG];
  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] prod_q, prod_next;
  logic [4:0]          mdst_q;
  logic                done_q, illegal_q;

  logic [4:0]        oper, rdst, rs1, rs2;
  logic              mode;
  logic [10:0]       imm;
  logic [DATA_W-1:0] opa, opb, res;
  logic [DATA_W:0]   sum, diff, msum;
  logic              c_bit, v_bit, is_mul, is_illegal, accept, mul_last;
  logic [3:0]        alu_flags, mul_flags;
  logic              wr_en;
  logic [4:0]        wr_idx;
  logic [DATA_W-1:0] wr_val;

  assign oper = bus.in_instr[31:27];
  assign rdst = bus.in_instr[26:22];
  assign rs1  = bus.in_instr[21:17];
  assign mode = bus.in_instr[16];
  assign rs2  = bus.in_instr[15:11];
  assign imm  = bus.in_instr[10:0];

  assign opa = (32'(rs1) < NREG) ? gpr[rs1[AW-1:0]] : '0;
  assign opb = mode ? {{(DATA_W-11){1'b0}}, imm}
                    : ((32'(rs2) < NREG) ? gpr[rs2[AW-1:0]] : '0);

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    res        = '0;
    c_bit      = 1'b0;
    v_bit      = 1'b0;
    is_mul     = 1'b0;
    is_illegal = 1'b0;
    case (oper)
      OP_MOVSGPR: res = sgpr;
      OP_MOV:     res = mode ? opb : opa;
      OP_ADD: begin
        res   = sum[DATA_W-1:0];
        c_bit = sum[DATA_W];
        v_bit = (opa[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_SUB: begin
        res   = diff[DATA_W-1:0];
        c_bit = diff[DATA_W];
        v_bit = (opa[DATA_W-1] != opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_MUL:     is_mul = 1'b1;
      OP_AND:     res = opa & opb;
      OP_OR:      res = opa | opb;
      OP_XOR:     res = opa ^ opb;
      default:    is_illegal = 1'b1;
    endcase
    alu_flags = {(res == '0), res[DATA_W-1], c_bit, v_bit};
  end

  // Right-shifting multiplier: low half starts as operand B and is consumed
  // one bit per step while the partial sum fills in from the top.
  assign msum      = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {msum, prod_q[DATA_W-1:1]};
  assign mul_flags = {(prod_next == '0), 1'b0, (prod_next[2*DATA_W-1:DATA_W] != '0), 1'b0};

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_last     = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && is_mul) begin
          state_d = MUL;
          cnt_d   = CW'(DATA_W - 1);
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          mul_last = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = rdst;
    wr_val = res;
    if (mul_last) begin
      wr_en  = 1'b1;
      wr_idx = mdst_q;
      wr_val = prod_next[DATA_W-1:0];
    end else if (accept && !is_mul && !is_illegal) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
      sgpr      <= '0;
      flags     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      mdst_q    <= '0;
    end else begin
      done_q    <= (accept && !is_mul) || mul_last;
      illegal_q <= accept && is_illegal;
      if (accept && is_mul) begin
        mcand_q <= opa;
        prod_q  <= {{DATA_W{1'b0}}, opb};
        mdst_q  <= rdst;
      end else if (state_q == MUL) begin
        prod_q <= prod_next;
      end
      if (mul_last) begin
        flags <= mul_flags;
        sgpr  <= prod_next[2*DATA_W-1:DATA_W];
      end else if (accept && !is_mul && !is_illegal) begin
        flags <= alu_flags;
      end
      if (wr_en && (32'(wr_idx) < NREG)) gpr[wr_idx[AW-1:0]] <= wr_val;
    end
  end

  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign dbg_data    = (32'(dbg_addr) < NREG) ? gpr[dbg_addr[AW-1:0]] : '0;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (DATA_W=16, NREG=8) with a done-driven scoreboard.
module tb_exec_unit;
  localparam int DW = 16;

  typedef struct packed {
    logic          ill;
    logic [3:0]    fl;
    logic [DW-1:0] sg;
    logic [4:0]    idx;
    logic [DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    flags;
  logic [DW-1:0] sgpr, dbg_data;
  logic [4:0]    dbg_addr, mon_addr = '0, stim_addr = '0;
  logic          use_mon = 1'b0;
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, acc = 0;
  exp_t          q[$];

  exec_unit_if bus();

  exec_unit #(.DATA_W(DW), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flags(flags), .sgpr(sgpr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign dbg_addr = use_mon ? mon_addr : stim_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] r1, input logic md,
                                      input logic [4:0] r2, input logic [10:0] im);
    return {op, rd, r1, md, r2, im};
  endfunction

  // Presents an instruction at a negedge, holds it until in_ready, and records
  // the counter value of the accepting edge in acc.
  task automatic issue(input logic [31:0] ins, input logic ill, input logic [3:0] fl,
                       input logic [DW-1:0] sg, input logic [4:0] idx,
                       input logic [DW-1:0] val, input bit push);
    int w;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    if (push) q.push_back('{ill, fl, sg, idx, val});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic op(input logic [31:0] ins, input logic [3:0] fl, input logic [DW-1:0] sg,
                    input logic [4:0] idx, input logic [DW-1:0] val);
    issue(ins, 1'b0, fl, sg, idx, val, 1'b1);
  endtask

  // Monitor: every done pulse retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("illegal", 32'(bus.illegal), 32'(e.ill));
          chk("flags", 32'(flags), 32'(e.fl));
          chk("sgpr", 32'(sgpr), 32'(e.sg));
          mon_addr = e.idx;
          use_mon  = 1'b1;
          #1;
          chk("rdst_value", 32'(dbg_data), 32'(e.val));
          use_mon = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, a1, a2;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    stim_addr    = 5'd1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_sgpr", 32'(sgpr), 32'd0);
    chk("rst_dbg", 32'(dbg_data), 32'd0);
    rst_n = 1'b1;

    op(enc(1, 1, 0, 1, 0, 11'h7FF), 4'b0000, 16'h0, 5'd1, 16'h07FF);
    op(enc(2, 2, 1, 1, 0, 11'h001), 4'b0000, 16'h0, 5'd2, 16'h0800);
    chk("in_ready_after_alu", 32'(bus.in_ready), 32'd1);
    op(enc(3, 3, 0, 1, 0, 11'h001), 4'b0110, 16'h0, 5'd3, 16'hFFFF);
    op(enc(2, 4, 3, 1, 0, 11'h001), 4'b1010, 16'h0, 5'd4, 16'h0000);
    op(enc(2, 6, 2, 0, 2, 11'h000), 4'b0000, 16'h0, 5'd6, 16'h1000);
    op(enc(2, 6, 6, 0, 6, 11'h000), 4'b0000, 16'h0, 5'd6, 16'h2000);
    op(enc(2, 6, 6, 0, 6, 11'h000), 4'b0000, 16'h0, 5'd6, 16'h4000);
    op(enc(2, 6, 6, 0, 6, 11'h000), 4'b0101, 16'h0, 5'd6, 16'h8000);
    op(enc(3, 5, 6, 1, 0, 11'h001), 4'b0001, 16'h0, 5'd5, 16'h7FFF);
    op(enc(2, 5, 5, 1, 0, 11'h001), 4'b0101, 16'h0, 5'd5, 16'h8000);
    op(enc(2, 6, 2, 0, 2, 11'h000), 4'b0000, 16'h0, 5'd6, 16'h1000);
    op(enc(2, 6, 6, 1, 0, 11'h234), 4'b0000, 16'h0, 5'd6, 16'h1234);
    op(enc(2, 7, 2, 0, 2, 11'h000), 4'b0000, 16'h0, 5'd7, 16'h1000);
    op(enc(2, 7, 7, 0, 7, 11'h000), 4'b0000, 16'h0, 5'd7, 16'h2000);
    op(enc(2, 7, 7, 0, 7, 11'h000), 4'b0000, 16'h0, 5'd7, 16'h4000);
    op(enc(2, 7, 7, 0, 6, 11'h000), 4'b0000, 16'h0, 5'd7, 16'h5234);
    op(enc(2, 7, 7, 1, 0, 11'h444), 4'b0000, 16'h0, 5'd7, 16'h5678);

    op(enc(4, 6, 6, 0, 7, 11'h000), 4'b0010, 16'h0626, 5'd6, 16'h0060);
    lo = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      lo++;
    end
    chk("mul_busy_cycles", 32'(lo), 32'd16);
    op(enc(0, 7, 0, 0, 0, 11'h000), 4'b0000, 16'h0626, 5'd7, 16'h0626);

    op(enc(5, 1, 7, 1, 0, 11'h0F0), 4'b0000, 16'h0626, 5'd1, 16'h0020);
    op(enc(6, 2, 7, 1, 0, 11'h100), 4'b0000, 16'h0626, 5'd2, 16'h0726);
    op(enc(7, 3, 7, 0, 7, 11'h000), 4'b1000, 16'h0626, 5'd3, 16'h0000);
    op(enc(4, 0, 0, 0, 0, 11'h000), 4'b1000, 16'h0000, 5'd0, 16'h0000);

    // The follow-up instruction is held valid through the whole multiply.
    op(enc(4, 4, 5, 1, 0, 11'h002), 4'b0010, 16'h0001, 5'd4, 16'h0000);
    a1 = acc;
    op(enc(5, 1, 1, 1, 0, 11'h000), 4'b1000, 16'h0001, 5'd1, 16'h0000);
    a2 = acc;
    chk("held_accept_gap", 32'(a2 - a1), 32'd17);

    op(enc(2, 1, 1, 1, 0, 11'h001), 4'b0000, 16'h0001, 5'd1, 16'h0001);
    a1 = acc;
    op(enc(2, 1, 1, 1, 0, 11'h001), 4'b0000, 16'h0001, 5'd1, 16'h0002);
    a2 = acc;
    chk("back_to_back_gap", 32'(a2 - a1), 32'd1);
    op(enc(2, 1, 1, 1, 0, 11'h001), 4'b0000, 16'h0001, 5'd1, 16'h0003);

    op(enc(2, 2, 31, 1, 0, 11'h005), 4'b0000, 16'h0001, 5'd2, 16'h0005);
    op(enc(3, 31, 0, 1, 0, 11'h001), 4'b0110, 16'h0001, 5'd31, 16'h0000);
    issue(enc(31, 1, 1, 1, 0, 11'h005), 1'b1, 4'b0110, 16'h0001, 5'd1, 16'h0003, 1'b1);
    @(negedge clk);

    issue(enc(4, 1, 1, 1, 0, 11'h003), 1'b0, 4'b0000, 16'h0, 5'd1, 16'h0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    stim_addr = 5'd1;
    #1;
    chk("midmul_rst_sgpr", 32'(sgpr), 32'd0);
    chk("midmul_rst_flags", 32'(flags), 32'd0);
    chk("midmul_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("midmul_rst_rdst", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("pending_expectations", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, clocked successor of the combinational register-file/ALU datapath. Accepts one 32-bit instruction per handshake, executes mov/add/sub/logic in one cycle and multiply iteratively over DATA_W cycles. Maintains a NREG×DATA_W general-purpose register file, the special high-product register SGPR, and a status-flag register. Sits between the instruction fetch/decode stage and the core's debug/observation logic.

## Interface
- DATA_W, 16, register and operand width; legal range 12..32.
- NREG, 32, number of general-purpose registers; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction valid.
- in_instr  in  32  instruction: oper[31:27], rdst[26:22], rsrc1[21:17], mode[16], rsrc2[15:11], imm[10:0].
- in_ready  out  1  unit can accept an instruction.
- done  out  1  one-cycle pulse; an instruction retired on the previous edge.
- illegal  out  1  one-cycle pulse, coincident with done; retired opcode was undefined.
- flags  out  4  {Z, N, C, V}, registered.
- sgpr  out  DATA_W  current SGPR.
- dbg_addr  in  5  register-file read address.
- dbg_data  out  DATA_W  combinational read of GPR[dbg_addr]; 0 when dbg_addr ≥ NREG.

## Operation
- Accept on a rising edge with in_valid && in_ready.
- Operand B is GPR[rsrc2] when mode=0, or imm zero-extended to DATA_W when mode=1.
- Opcodes:
  - 00000 movsgpr: rdst ← SGPR.
  - 00001 mov: rdst ← B when mode=1, GPR[rsrc1] when mode=0.
  - 00010 add: rdst ← A+B.
  - 00011 sub: rdst ← A−B.
  - 00100 mul: {SGPR, rdst} ← A×B, unsigned, 2·DATA_W-bit product.
  - 00101 and, 00110 or, 00111 xor: bitwise A op B.
  - All others: illegal. No register or flag write; done and illegal both pulse.
- Here A = GPR[rsrc1]. A register index ≥ NREG reads as 0; a write to it is discarded, but flags still update.
- Results are truncated to DATA_W.
- Flags, from the written result R:
  - Z = (R==0); N = R[DATA_W−1].
  - add: C = carry-out; V = signed overflow.
  - sub: C = borrow (A<B unsigned); V = signed overflow.
  - mul: Z = (full product==0); N = 0; C = (high half≠0); V = 0.
  - mov, movsgpr and logic ops: C = V = 0.
- Multiplier state machine:
  - IDLE: accept a mul, then go to MUL with the counter at DATA_W−1.
  - MUL: one shift-add step per cycle; the last step writes rdst, SGPR and flags, then returns to IDLE.
  - Operands are captured at acceptance. Register changes during MUL are impossible, since no issue occurs while busy.
- Reset clears GPR[*], SGPR and flags to 0. It also sets IDLE, in_ready=1, done=0, illegal=0 and dbg_data=0. A multiply in progress is aborted with no write.

## Timing
- Single-cycle ops: accepted at edge N; result, flags and done are visible after edge N. in_ready stays 1, so back-to-back issue is allowed.
- An instruction accepted at edge N+1 reads the value written at edge N; no hazard exists.
- mul:
  - Accepted at edge N; in_ready=0 from after edge N.
  - Result written at edge N+DATA_W, with done high in the following cycle.
  - in_ready=1 again after edge N+DATA_W, so the next accept is at edge N+DATA_W+1 at the earliest.
- in_valid while in_ready=0 is ignored; the producer must hold the instruction.
- rdst = rsrc1 is legal: the old value is used and the new value written.
- mul with rdst = 0 and the other default fields still writes SGPR.
- Reset asserted mid-MUL: state clears immediately (asynchronous).

## Test plan
- Reset, then mov r1 ← imm 11'h7FF; add r2 = r1 + imm 1 → r2=0x0800; flags Z=0, N=0, C=0, V=0; done pulses each instruction; in_ready stays 1.
- DATA_W=16: r3=0xFFFF, add r4 = r3 + imm 1 → r4=0x0000, Z=1, C=1, V=0. Then r5=0x7FFF, add imm 1 → 0x8000, N=1, V=1. Then sub 0 − 1 → 0xFFFF, C=1.
- mul r6 = 0x1234 × 0x5678 (mode 0) → r6=0x0060, SGPR=0x0626, C=1; in_ready low for exactly 16 cycles. Then movsgpr r7 → r7=0x0626.
- Hold in_valid through a mul and verify no second accept until in_ready rises. Back-to-back add r1=r1+imm 1 ×3 from 0 → r1=3.
- Opcode 11111 → illegal and done pulse together, no register or flag change. Write to index 31 with NREG=8 → discarded, dbg_addr=31 reads 0.
- Assert rst_n=0 at cycle 5 of a mul → sgpr=0, flags=0, rdst=0, in_ready=1 immediately; no done pulse after release.
